// File: rtl/rtc_alarm_scheduler.sv
// Alarm scheduler: multiplexes several software alarm times onto one RTC match comparator.
// The enabled alarms are scanned one per cycle, the soonest relative to Count (wrap-aware) is loaded.
module rtc_alarm_scheduler #(
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned IDX_W      = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [31:0]           Count,
  input  logic                  RawIntEdge,
  input  logic                  AlarmWr,
  input  logic                  AlarmDis,
  input  logic [IDX_W-1:0]      AlarmIdx,
  input  logic [31:0]           AlarmWrData,
  input  logic [NUM_ALARMS-1:0] StatusClr,
  output logic [31:0]           MatchData,
  output logic                  MatchValid,
  output logic [NUM_ALARMS-1:0] AlarmEnable,
  output logic [NUM_ALARMS-1:0] AlarmStatus,
  output logic                  AlarmHit,
  output logic                  Busy
);

  localparam logic [1:0]       ST_IDLE  = 2'd0;
  localparam logic [1:0]       ST_SCAN  = 2'd1;
  localparam logic [1:0]       ST_LOAD  = 2'd2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ALARMS - 1);

  logic [31:0]           alarmTime     [NUM_ALARMS];
  logic [31:0]           alarmTimeNext [NUM_ALARMS];
  logic [1:0]            state, stateNext;
  logic [IDX_W-1:0]      scanIdx, scanIdxNext;
  logic                  bestValid, bestValidNext;
  logic [31:0]           bestDelta, bestDeltaNext;
  logic [31:0]           bestTime, bestTimeNext;
  logic                  rescan, rescanNext;
  logic [NUM_ALARMS-1:0] enableNext, statusNext, retireMask;
  logic [31:0]           matchDataNext, scanDelta;
  logic                  matchValidNext, hitNext, busyNext, trigger;

  // Next-state, storage update and scan datapath
  always_comb begin
    stateNext      = state;
    scanIdxNext    = scanIdx;
    bestValidNext  = bestValid;
    bestDeltaNext  = bestDelta;
    bestTimeNext   = bestTime;
    matchDataNext  = MatchData;
    matchValidNext = MatchValid;
    alarmTimeNext  = alarmTime;
    enableNext     = AlarmEnable;
    retireMask     = '0;
    scanDelta      = alarmTime[scanIdx] - Count;

    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (RawIntEdge && MatchValid && AlarmEnable[i] && (alarmTime[i] == MatchData))
        retireMask[i] = 1'b1;
    end

    // Priority per slot: disable > write > retirement
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (retireMask[i])
        enableNext[i] = 1'b0;
      if (AlarmWr && (AlarmIdx == IDX_W'(i))) begin
        alarmTimeNext[i] = AlarmWrData;
        enableNext[i]    = 1'b1;
      end
      if (AlarmDis && (AlarmIdx == IDX_W'(i)))
        enableNext[i] = 1'b0;
    end

    statusNext = (AlarmStatus & ~StatusClr) | retireMask;
    hitNext    = |retireMask;
    trigger    = AlarmWr | AlarmDis | hitNext;
    rescanNext = rescan | trigger;

    case (state)
      ST_IDLE: begin
        if (rescan) begin
          stateNext     = ST_SCAN;
          scanIdxNext   = '0;
          bestValidNext = 1'b0;
          rescanNext    = trigger;
        end
      end
      ST_SCAN: begin
        if (AlarmEnable[scanIdx] && (!bestValid || (scanDelta < bestDelta))) begin
          bestValidNext = 1'b1;
          bestDeltaNext = scanDelta;
          bestTimeNext  = alarmTime[scanIdx];
        end
        if (scanIdx == LAST_IDX)
          stateNext = ST_LOAD;
        else
          scanIdxNext = scanIdx + IDX_W'(1);
      end
      ST_LOAD: begin
        matchValidNext = bestValid;
        if (bestValid)
          matchDataNext = bestTime;
        rescanNext = trigger;
        if (rescan) begin
          stateNext     = ST_SCAN;
          scanIdxNext   = '0;
          bestValidNext = 1'b0;
        end else begin
          stateNext = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase

    busyNext = (stateNext != ST_IDLE) | rescanNext;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= ST_IDLE;
      scanIdx     <= '0;
      bestValid   <= 1'b0;
      bestDelta   <= '0;
      bestTime    <= '0;
      rescan      <= 1'b0;
      MatchData   <= '0;
      MatchValid  <= 1'b0;
      AlarmEnable <= '0;
      AlarmStatus <= '0;
      AlarmHit    <= 1'b0;
      Busy        <= 1'b0;
      for (int unsigned i = 0; i < NUM_ALARMS; i++)
        alarmTime[i] <= '0;
    end else begin
      state       <= stateNext;
      scanIdx     <= scanIdxNext;
      bestValid   <= bestValidNext;
      bestDelta   <= bestDeltaNext;
      bestTime    <= bestTimeNext;
      rescan      <= rescanNext;
      MatchData   <= matchDataNext;
      MatchValid  <= matchValidNext;
      AlarmEnable <= enableNext;
      AlarmStatus <= statusNext;
      AlarmHit    <= hitNext;
      Busy        <= busyNext;
      alarmTime   <= alarmTimeNext;
    end
  end

endmodule

// File: tb/tb_rtc_alarm_scheduler.sv
// Bench for rtc_alarm_scheduler: abstract reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_rtc_alarm_scheduler;

  localparam int unsigned NUM_ALARMS = 4;
  localparam int unsigned IDX_W      = 2;

  logic                  PCLK, PRESET, RawIntEdge, AlarmWr, AlarmDis;
  logic [31:0]           Count, AlarmWrData, MatchData;
  logic [IDX_W-1:0]      AlarmIdx;
  logic [NUM_ALARMS-1:0] StatusClr, AlarmEnable, AlarmStatus;
  logic                  MatchValid, AlarmHit, Busy;

  rtc_alarm_scheduler #(.NUM_ALARMS(NUM_ALARMS), .IDX_W(IDX_W)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .Count(Count), .RawIntEdge(RawIntEdge),
    .AlarmWr(AlarmWr), .AlarmDis(AlarmDis), .AlarmIdx(AlarmIdx),
    .AlarmWrData(AlarmWrData), .StatusClr(StatusClr), .MatchData(MatchData),
    .MatchValid(MatchValid), .AlarmEnable(AlarmEnable), .AlarmStatus(AlarmStatus),
    .AlarmHit(AlarmHit), .Busy(Busy)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  int nChecks = 0;
  int nFail   = 0;
  bit chkOn   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: alarm table plus an abstract "result ready 6 edges after a
  // trigger, one 5-edge rescan if anything changed meanwhile" busy window.
  logic [31:0]           mTime [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] mEn, mStat;
  logic [31:0]           mMD;
  logic                  mMV, mHit, mBusy;
  int                    cyc, eEnd;
  bit                    active, deferred;

  always @(posedge PCLK) begin
    logic [NUM_ALARMS-1:0] ret;
    logic [31:0]           d, bd, bt;
    bit                    bok, trig;
    cyc++;
    if (PRESET) begin
      for (int i = 0; i < NUM_ALARMS; i++) mTime[i] = 32'h0;
      mEn = '0; mStat = '0; mMD = 32'h0; mMV = 1'b0; mHit = 1'b0;
      active = 1'b0; deferred = 1'b0; mBusy = 1'b0;
    end else begin
      ret = '0;
      for (int i = 0; i < NUM_ALARMS; i++)
        if (RawIntEdge && mMV && mEn[i] && mTime[i] == mMD) ret[i] = 1'b1;
      trig = AlarmWr || AlarmDis || (ret != '0);
      if (active && cyc == eEnd) begin
        bok = 1'b0; bd = 32'h0; bt = 32'h0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
          d = mTime[i] - Count;
          if (mEn[i] && (!bok || d < bd)) begin bok = 1'b1; bd = d; bt = mTime[i]; end
        end
        mMV = bok;
        if (bok) mMD = bt;
        if (deferred) begin eEnd = eEnd + 5; deferred = trig; end
        else if (trig) begin eEnd = cyc + 6; deferred = 1'b0; end
        else active = 1'b0;
      end else if (active) begin
        deferred = deferred || trig;
      end else if (trig) begin
        active = 1'b1; eEnd = cyc + 6; deferred = 1'b0;
      end
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (ret[i]) mEn[i] = 1'b0;
        if (AlarmWr && AlarmIdx == IDX_W'(i)) begin mTime[i] = AlarmWrData; mEn[i] = 1'b1; end
        if (AlarmDis && AlarmIdx == IDX_W'(i)) mEn[i] = 1'b0;
      end
      mStat = (mStat & ~StatusClr) | ret;
      mHit  = (ret != '0);
      mBusy = active;
    end
  end

  // Every-cycle comparison against the model; match outputs only once settled
  always @(negedge PCLK) begin
    if (chkOn) begin
      check("m_AlarmEnable", 32'(AlarmEnable), 32'(mEn));
      check("m_AlarmStatus", 32'(AlarmStatus), 32'(mStat));
      check("m_AlarmHit", 32'(AlarmHit), 32'(mHit));
      check("m_Busy", 32'(Busy), 32'(mBusy));
      if (!mBusy) begin
        check("m_MatchValid", 32'(MatchValid), 32'(mMV));
        check("m_MatchData", MatchData, mMD);
      end
    end
  end

  task automatic wr(input int idx, input logic [31:0] data);
    AlarmWr = 1'b1; AlarmIdx = IDX_W'(idx); AlarmWrData = data;
    @(negedge PCLK);
    AlarmWr = 1'b0;
  endtask

  task automatic dis(input int idx);
    AlarmDis = 1'b1; AlarmIdx = IDX_W'(idx);
    @(negedge PCLK);
    AlarmDis = 1'b0;
  endtask

  task automatic pulse();
    RawIntEdge = 1'b1;
    @(negedge PCLK);
    RawIntEdge = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (Busy !== 1'b0 && n < 64) begin
      @(negedge PCLK);
      n++;
    end
    check("idle_wait", 32'(Busy), 32'h0);
  endtask

  initial begin
    int n;
    PRESET = 1'b1; Count = 32'h0; RawIntEdge = 1'b0; AlarmWr = 1'b0; AlarmDis = 1'b0;
    AlarmIdx = '0; AlarmWrData = 32'h0; StatusClr = '0;
    repeat (2) @(negedge PCLK);
    chkOn = 1'b1;
    check("rst_MatchData", MatchData, 32'h0);
    check("rst_MatchValid", 32'(MatchValid), 32'h0);
    check("rst_AlarmEnable", 32'(AlarmEnable), 32'h0);
    check("rst_Busy", 32'(Busy), 32'h0);
    PRESET = 1'b0;
    @(negedge PCLK);

    // Single alarm: six busy cycles, then scheduled
    Count = 32'h50;
    wr(2, 32'h100);
    n = 0;
    while (Busy === 1'b1 && n < 64) begin n++; @(negedge PCLK); end
    check("t1_busy_len", 32'(n), 32'd6);
    check("t1_MatchData", MatchData, 32'h100);
    check("t1_MatchValid", 32'(MatchValid), 32'h1);
    check("t1_AlarmEnable", 32'(AlarmEnable), 32'h4);

    // Tie between slots 1 and 3, both retire on one match
    Count = 32'h100;
    wr(0, 32'h300); wr(1, 32'h120); wr(2, 32'h200); wr(3, 32'h120);
    waitIdle();
    check("t2_MatchData", MatchData, 32'h120);
    pulse();
    check("t2_AlarmHit", 32'(AlarmHit), 32'h1);
    check("t2_AlarmStatus", 32'(AlarmStatus), 32'hA);
    check("t2_AlarmEnable", 32'(AlarmEnable), 32'h5);
    @(negedge PCLK);
    check("t2_AlarmHit_off", 32'(AlarmHit), 32'h0);
    waitIdle();
    check("t2_MatchData_next", MatchData, 32'h200);

    // Wrap-around ordering
    StatusClr = 4'hF; @(negedge PCLK); StatusClr = '0;
    dis(0); dis(1); dis(2); dis(3);
    waitIdle();
    Count = 32'hFFFF_FFF0;
    wr(0, 32'h10); wr(1, 32'hFFFF_FFF8);
    waitIdle();
    check("t3_MatchData", MatchData, 32'hFFFF_FFF8);
    pulse();
    waitIdle();
    check("t3_MatchData_wrap", MatchData, 32'h10);
    check("t3_AlarmStatus", 32'(AlarmStatus), 32'h2);

    // Write during the second scan cycle forces one rescan
    Count = 32'h0;
    wr(2, 32'h80);
    n = 0;
    repeat (2) begin if (Busy === 1'b1) n++; @(negedge PCLK); end
    if (Busy === 1'b1) n++;
    wr(1, 32'h5);
    while (Busy === 1'b1 && n < 64) begin n++; @(negedge PCLK); end
    check("t4_busy_len", 32'(n), 32'd11);
    check("t4_MatchData", MatchData, 32'h5);

    // Disable everything: MatchValid drops, data holds, match edges ignored
    dis(0); dis(2);
    waitIdle();
    check("t5_MatchData_pre", MatchData, 32'h5);
    dis(1);
    waitIdle();
    check("t5_MatchValid", 32'(MatchValid), 32'h0);
    check("t5_MatchData_hold", MatchData, 32'h5);
    pulse();
    check("t5_AlarmHit", 32'(AlarmHit), 32'h0);
    check("t5_AlarmStatus", 32'(AlarmStatus), 32'h2);

    // Retirement, status clear and rewrite of the same slot in one cycle
    Count = 32'h400;
    wr(0, 32'h450);
    waitIdle();
    check("t6_MatchData_pre", MatchData, 32'h450);
    RawIntEdge = 1'b1; StatusClr = 4'h1; AlarmWr = 1'b1; AlarmIdx = 2'd0; AlarmWrData = 32'h500;
    @(negedge PCLK);
    RawIntEdge = 1'b0; StatusClr = '0; AlarmWr = 1'b0;
    check("t6_AlarmStatus", 32'(AlarmStatus), 32'h3);
    check("t6_AlarmEnable", 32'(AlarmEnable), 32'h1);
    check("t6_AlarmHit", 32'(AlarmHit), 32'h1);
    waitIdle();
    check("t6_MatchData", MatchData, 32'h500);

    // Write and disable of one slot together: disable wins
    AlarmWr = 1'b1; AlarmDis = 1'b1; AlarmIdx = 2'd3; AlarmWrData = 32'h410;
    @(negedge PCLK);
    AlarmWr = 1'b0; AlarmDis = 1'b0;
    check("t7_AlarmEnable", 32'(AlarmEnable), 32'h1);
    waitIdle();
    check("t7_MatchData", MatchData, 32'h500);

    repeat (2) @(negedge PCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
